// File: rtl/swarm_pkg.sv
// Shared types and constants for the RW write-back path.
// Entry structs are sized for the widest supported build; unused bits are constant zero.
package swarm;

    localparam int LOG_RW_WIDTH_DEFAULT = 2;
    localparam logic [31:0] RW_BASE_ADDR = 32'h0000_1000;

    localparam int MAX_TID_W  = 16;
    localparam int MAX_SLOT_W = 16;
    localparam int MAX_OBJ_W  = 512;

    typedef struct packed {
        logic [MAX_TID_W-1:0] thread;
        logic [31:0]          locale;
        logic [MAX_OBJ_W-1:0] object;
    } rw_wb_entry_t;

    typedef struct packed {
        logic [MAX_SLOT_W-1:0] slot;
        logic                  is_restore;
    } finish_entry_t;

endpackage

// File: rtl/fifo.sv
// Generic first-word-fall-through FIFO; push while full is accepted when a pop happens in the same cycle.
module fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic                 empty,
    output logic                 full,
    output logic [LOG_DEPTH:0]   count
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] rd_ptr, wr_ptr;
    logic                 do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = count[LOG_DEPTH];
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/rw_writeback_unit_lane_pack.sv
// Maps an object write onto a 64-byte data-array line: line address, replicated data, byte strobes.
module rw_wb_lane_pack import swarm::*; #(
    parameter int LOG_RW_WIDTH = LOG_RW_WIDTH_DEFAULT
) (
    input  logic [31:0]                  base_addr,
    input  logic [31:0]                  locale,
    input  logic [(8<<LOG_RW_WIDTH)-1:0] object,
    output logic [31:0]                  waddr,
    output logic [511:0]                 wdata,
    output logic [63:0]                  wstrb
);
    localparam int BYTES = 1 << LOG_RW_WIDTH;
    localparam int LANES = 64 / BYTES;
    localparam logic [63:0] OBJ_STRB = ~64'd0 >> (64 - BYTES);

    logic [31:0] byte_addr;
    logic [5:0]  lane;

    assign byte_addr = base_addr + (locale << LOG_RW_WIDTH);
    assign waddr     = {byte_addr[31:6], 6'b0};
    assign wdata     = {LANES{object}};
    assign wstrb     = OBJ_STRB << (32'(lane) * BYTES);

    generate
        if (LOG_RW_WIDTH == 6) begin : g_one_lane
            assign lane = '0;
        end else begin : g_lanes
            assign lane = 6'(locale[5-LOG_RW_WIDTH:0]);
        end
    endgenerate
endmodule

// File: rtl/rw_writeback_unit.sv
// RW worker commit stage: queues object writes to L2, tracks in-flight writes, unlocks threads, notifies CQ.
// Optional drain/flush handshake is built when RW_WB_FLUSH_EN is defined.
module rw_writeback_unit import swarm::*; #(
    parameter int LOG_RW_WIDTH    = LOG_RW_WIDTH_DEFAULT,
    parameter int WQ_LOG_DEPTH    = 2,
    parameter int FQ_LOG_DEPTH    = 1,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TID_W           = 4,
    parameter int SLOT_W          = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_wen,
    input  logic                         req_restore,
    input  logic [31:0]                  req_locale,
    input  logic [TID_W-1:0]             req_thread,
    input  logic [SLOT_W-1:0]            req_slot,
    input  logic [(8<<LOG_RW_WIDTH)-1:0] req_data,
    input  logic [31:0]                  cfg_base_addr,
    output logic                         wvalid,
    input  logic                         wready,
    output logic [31:0]                  waddr,
    output logic [511:0]                 wdata,
    output logic [63:0]                  wstrb,
    output logic [TID_W-1:0]             wid,
    input  logic                         bvalid,
    output logic                         bready,
    input  logic [TID_W-1:0]             bid,
    output logic                         unlock_valid,
    output logic [TID_W-1:0]             unlock_thread,
`ifdef RW_WB_FLUSH_EN
    input  logic                         flush_req,
    output logic                         flush_done,
`endif
    output logic                         finish_valid,
    input  logic                         finish_ready,
    output logic [SLOT_W-1:0]            finish_slot,
    output logic                         finish_is_restore,
    output logic [7:0]                   outstanding
);
    localparam int OBJ_W = 8 << LOG_RW_WIDTH;

    rw_wb_entry_t          wq_in, wq_head;
    finish_entry_t         fq_in, fq_head;
    logic                  wq_empty, wq_full, fq_empty, fq_full;
    logic [WQ_LOG_DEPTH:0] wq_count;
    logic [FQ_LOG_DEPTH:0] fq_count;
    logic                  is_write, under_cap, flush_block, wfire, bfire;
    logic [31:0]           head_addr;
    logic [511:0]          head_data;
    logic [63:0]           head_strb;
    logic                  unused_bits;

    assign is_write  = req_wen | req_restore;
    // Queued writes count against the cap too, so the limit holds once they issue.
    assign under_cap = (10'(wq_count) + 10'(outstanding)) < 10'(MAX_OUTSTANDING);
    assign req_ready = req_valid & !fq_full & !flush_block
                     & (!is_write | (!wq_full & under_cap));

    assign wq_in = '{thread: MAX_TID_W'(req_thread), locale: req_locale,
                     object: MAX_OBJ_W'(req_data)};
    assign fq_in = '{slot: MAX_SLOT_W'(req_slot), is_restore: req_restore};

    fifo #(.WIDTH($bits(rw_wb_entry_t)), .LOG_DEPTH(WQ_LOG_DEPTH)) u_wq (
        .clk(clk), .rst(rst), .push(req_ready & is_write), .push_data(wq_in),
        .pop(wready), .head(wq_head), .empty(wq_empty), .full(wq_full), .count(wq_count)
    );

    fifo #(.WIDTH($bits(finish_entry_t)), .LOG_DEPTH(FQ_LOG_DEPTH)) u_fq (
        .clk(clk), .rst(rst), .push(req_ready), .push_data(fq_in),
        .pop(finish_ready), .head(fq_head), .empty(fq_empty), .full(fq_full), .count(fq_count)
    );

    rw_wb_lane_pack #(.LOG_RW_WIDTH(LOG_RW_WIDTH)) u_pack (
        .base_addr(cfg_base_addr), .locale(wq_head.locale), .object(wq_head.object[OBJ_W-1:0]),
        .waddr(head_addr), .wdata(head_data), .wstrb(head_strb)
    );

    assign wvalid            = !wq_empty;
    assign wid               = wq_head.thread[TID_W-1:0];
    assign waddr             = wvalid ? head_addr : '0;
    assign wdata             = wvalid ? head_data : '0;
    assign wstrb             = wvalid ? head_strb : '0;
    assign finish_valid      = !fq_empty;
    assign finish_slot       = fq_head.slot[SLOT_W-1:0];
    assign finish_is_restore = fq_head.is_restore;
    assign unused_bits       = ^{wq_head, fq_head, fq_count};

    // One unlock port: a no-write commit wins and holds off the response for a cycle.
    always_comb begin
        bready        = 1'b0;
        unlock_valid  = 1'b0;
        unlock_thread = bid;
        if (req_ready & !is_write) begin
            unlock_valid  = 1'b1;
            unlock_thread = req_thread;
        end else begin
            bready       = bvalid & (outstanding != 8'd0);
            unlock_valid = bready;
        end
    end

    assign wfire = wvalid & wready;
    assign bfire = bvalid & bready;

    always_ff @(posedge clk) begin
        if (rst)                 outstanding <= '0;
        else if (wfire & !bfire) outstanding <= outstanding + 8'd1;
        else if (bfire & !wfire) outstanding <= outstanding - 8'd1;
    end

`ifdef RW_WB_FLUSH_EN
    typedef enum logic {FL_IDLE, FL_DRAIN} flush_state_t;
    flush_state_t fl_state, fl_next;
    logic         drained;

    assign drained     = wq_empty & fq_empty & (outstanding == 8'd0) & !flush_req;
    assign flush_block = (fl_state == FL_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) fl_state <= FL_IDLE;
        else     fl_state <= fl_next;
    end

    always_comb begin
        fl_next    = fl_state;
        flush_done = 1'b0;
        case (fl_state)
            FL_IDLE:  if (flush_req) fl_next = FL_DRAIN;
            FL_DRAIN: if (drained) begin
                fl_next    = FL_IDLE;
                flush_done = 1'b1;
            end
            default:  fl_next = FL_IDLE;
        endcase
    end
`else
    assign flush_block = 1'b0;
`endif
endmodule

// File: tb/tb_rw_writeback_unit.sv
// Self-checking bench for rw_writeback_unit: address/strobe table, directed corner sequences, random vs queue model.
module tb_rw_writeback_unit;
    localparam int TID_W = 4, SLOT_W = 6, MAXO = 2, WQD = 4, FQD = 2;

    logic              clk, rst;
    logic              req_valid, req_ready, req_wen, req_restore;
    logic [31:0]       req_locale, cfg_base_addr, req_data;
    logic [TID_W-1:0]  req_thread, wid, bid, unlock_thread;
    logic [SLOT_W-1:0] req_slot, finish_slot;
    logic              wvalid, wready, bvalid, bready, unlock_valid;
    logic [31:0]       waddr;
    logic [511:0]      wdata;
    logic [63:0]       wstrb;
    logic              finish_valid, finish_ready, finish_is_restore;
    logic [7:0]        outstanding;
`ifdef RW_WB_FLUSH_EN
    logic              flush_req, flush_done;
`endif

    int errors = 0;
    int checks = 0;

    rw_writeback_unit #(
        .LOG_RW_WIDTH(2), .WQ_LOG_DEPTH(2), .FQ_LOG_DEPTH(1),
        .MAX_OUTSTANDING(MAXO), .TID_W(TID_W), .SLOT_W(SLOT_W)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_restore(req_restore), .req_locale(req_locale),
        .req_thread(req_thread), .req_slot(req_slot), .req_data(req_data),
        .cfg_base_addr(cfg_base_addr), .wvalid(wvalid), .wready(wready),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bid(bid),
        .unlock_valid(unlock_valid), .unlock_thread(unlock_thread),
`ifdef RW_WB_FLUSH_EN
        .flush_req(flush_req), .flush_done(flush_done),
`endif
        .finish_valid(finish_valid), .finish_ready(finish_ready),
        .finish_slot(finish_slot), .finish_is_restore(finish_is_restore),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] locale;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [63:0] exp_strb;
    } vec_t;

    typedef struct { logic [3:0] thread; logic [31:0] locale; logic [31:0] data; } wm_t;
    typedef struct { logic [5:0] slot; logic restore; } fm_t;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        req_valid = 0; req_wen = 0; req_restore = 0; req_locale = '0;
        req_thread = '0; req_slot = '0; req_data = '0;
        wready = 0; bvalid = 0; bid = '0; finish_ready = 0;
`ifdef RW_WB_FLUSH_EN
        flush_req = 0;
`endif
    endtask

    task automatic req(input logic wen, input logic rs, input logic [31:0] loc,
                       input logic [3:0] th, input logic [5:0] sl, input logic [31:0] d);
        req_valid = 1; req_wen = wen; req_restore = rs; req_locale = loc;
        req_thread = th; req_slot = sl; req_data = d;
    endtask

    task automatic drain();
        logic done = 1'b0;
        req_valid = 0; wready = 1; finish_ready = 1;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            bvalid = (outstanding != 0); bid = '0;
            #1;
            done = !wvalid && !finish_valid && outstanding == 0;
        end
        chk("drain_timeout", done, 1'b1);
        bvalid = 0; wready = 0; finish_ready = 0;
    endtask

    vec_t vecs[6];
    wm_t  wq_m[$];
    fm_t  fq_m[$];

    initial begin
        vecs[0] = '{32'h1000, 32'h11, 32'hDEADBEEF, 32'h1040, 64'h0000_0000_0000_00F0};
        vecs[1] = '{32'h1000, 32'h0, 32'h01234567, 32'h1000, 64'h0000_0000_0000_000F};
        vecs[2] = '{32'h1000, 32'hF, 32'hA5A5_5A5A, 32'h1000, 64'hF000_0000_0000_0000};
        vecs[3] = '{32'h0FFF_FFC0, 32'h10, 32'h1, 32'h1000_0000, 64'h0000_0000_0000_000F};
        vecs[4] = '{32'hFFFF_FFC0, 32'h20, 32'hCAFE_F00D, 32'h0000_0040, 64'h0000_0000_0000_000F};
        vecs[5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFC0, 64'hF000_0000_0000_0000};

        idle();
        cfg_base_addr = 32'h1000;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_wvalid", wvalid, 0);
        chk("rst_finish_valid", finish_valid, 0);
        chk("rst_unlock_valid", unlock_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", wstrb, 0);
        chk("rst_finish_slot", finish_slot, 0);

        // Response with nothing in flight must be ignored
        @(negedge clk); bvalid = 1; bid = 4'd5; #1;
        chk("stray_b_bready", bready, 0);
        chk("stray_b_unlock", unlock_valid, 0);
        @(negedge clk); bvalid = 0; #1;
        chk("stray_b_outstanding", outstanding, 0);

        // No-write commit unlocks immediately
        @(negedge clk); req(0, 0, 32'h7, 4'd3, 6'd5, 32'h0); #1;
        chk("nw_ready", req_ready, 1);
        chk("nw_unlock_valid", unlock_valid, 1);
        chk("nw_unlock_thread", unlock_thread, 4'd3);
        chk("nw_bready", bready, 0);
        @(negedge clk); req_valid = 0; #1;
        chk("nw_finish_valid", finish_valid, 1);
        chk("nw_finish_slot", finish_slot, 6'd5);
        chk("nw_finish_restore", finish_is_restore, 0);
        chk("nw_no_wvalid", wvalid, 0);
        drain();

        // Address / strobe / data table
        foreach (vecs[i]) begin
            logic [3:0] th;
            th = 4'(i + 1);
            @(negedge clk);
            cfg_base_addr = vecs[i].base;
            req(1, 0, vecs[i].locale, th, 6'(i + 10), vecs[i].data); #1;
            chk("tbl_ready", req_ready, 1);
            chk("tbl_no_early_unlock", unlock_valid, 0);
            @(negedge clk); req_valid = 0; #1;
            chk("tbl_wvalid", wvalid, 1);
            chk("tbl_waddr", waddr, vecs[i].exp_addr);
            chk("tbl_wstrb", wstrb, vecs[i].exp_strb);
            chk("tbl_wdata", wdata, {16{vecs[i].data}});
            chk("tbl_wid", wid, th);
            @(negedge clk); wready = 1;
            @(negedge clk); wready = 0; #1;
            chk("tbl_outstanding", outstanding, 1);
            chk("tbl_wait_unlock", unlock_valid, 0);
            @(negedge clk); bvalid = 1; bid = th; #1;
            chk("tbl_bready", bready, 1);
            chk("tbl_unlock_thread", unlock_thread, th);
            @(negedge clk); bvalid = 0; #1;
            chk("tbl_outstanding_done", outstanding, 0);
            drain();
        end
        cfg_base_addr = 32'h1000;

        // Outstanding cap (MAX_OUTSTANDING = 2)
        @(negedge clk); wready = 1; finish_ready = 1; req(1, 0, 32'h0, 4'd1, 6'd1, 32'h11); #1;
        chk("cap_req1", req_ready, 1);
        @(negedge clk); req(1, 0, 32'h1, 4'd2, 6'd2, 32'h22); #1;
        chk("cap_req2", req_ready, 1);
        @(negedge clk); req(1, 0, 32'h2, 4'd3, 6'd3, 32'h33); #1;
        chk("cap_req3_stall", req_ready, 0);
        @(negedge clk); bvalid = 1; bid = 4'd1; #1;
        chk("cap_still_stalled", req_ready, 0);
        chk("cap_outstanding", outstanding, 2);
        chk("cap_bready", bready, 1);
        chk("cap_unlock", unlock_thread, 4'd1);
        @(negedge clk); bvalid = 0; #1;
        chk("cap_req3_accept", req_ready, 1);
        drain();

        // Non-write accept collides with a write response
        @(negedge clk); wready = 1; finish_ready = 1; req(1, 0, 32'h4, 4'd6, 6'd6, 32'h66);
        @(negedge clk); req_valid = 0;
        @(negedge clk); wready = 0; req(0, 0, 32'h0, 4'd9, 6'd9, 32'h0); bvalid = 1; bid = 4'd6; #1;
        chk("sim_outstanding", outstanding, 1);
        chk("sim_unlock_req", unlock_thread, 4'd9);
        chk("sim_unlock_valid", unlock_valid, 1);
        chk("sim_bready_held", bready, 0);
        @(negedge clk); req_valid = 0; #1;
        chk("sim_bready_next", bready, 1);
        chk("sim_unlock_bid", unlock_thread, 4'd6);
        @(negedge clk); bvalid = 0; #1;
        chk("sim_outstanding_done", outstanding, 0);
        drain();

        // Finish-queue backpressure, then a restore without wen
        @(negedge clk); req(0, 0, 32'h0, 4'd1, 6'd1, 32'h0); #1;
        chk("bp_req1", req_ready, 1);
        @(negedge clk); req(0, 0, 32'h0, 4'd2, 6'd2, 32'h0); #1;
        chk("bp_req2", req_ready, 1);
        @(negedge clk); req(0, 0, 32'h0, 4'd3, 6'd3, 32'h0); #1;
        chk("bp_req3_stall", req_ready, 0);
        chk("bp_head_slot", finish_slot, 6'd1);
        drain();
        @(negedge clk); req(0, 1, 32'h5, 4'd4, 6'd7, 32'h5555); #1;
        chk("rs_ready", req_ready, 1);
        chk("rs_no_unlock", unlock_valid, 0);
        @(negedge clk); req_valid = 0; #1;
        chk("rs_wvalid", wvalid, 1);
        chk("rs_wid", wid, 4'd4);
        chk("rs_finish_restore", finish_is_restore, 1);
        chk("rs_finish_slot", finish_slot, 6'd7);
        drain();

        // Randomized traffic against a queue model
        cfg_base_addr = $urandom;
        begin
            int out_m = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic is_w, e_ready, e_bready, e_wv, e_fv;
                logic [31:0] a;
                @(negedge clk);
                req_valid = ($urandom_range(1, 0) == 1);
                req_wen = ($urandom_range(1, 0) == 1);
                req_restore = ($urandom_range(7, 0) == 0);
                req_locale = $urandom; req_thread = 4'($urandom); req_slot = 6'($urandom);
                req_data = $urandom;
                wready = ($urandom_range(9, 0) < 6);
                bvalid = ($urandom_range(1, 0) == 1); bid = 4'($urandom);
                finish_ready = ($urandom_range(9, 0) < 6);
                #1;
                is_w = req_wen | req_restore;
                e_ready = req_valid && fq_m.size() < FQD &&
                          (!is_w || (wq_m.size() < WQD && wq_m.size() + out_m < MAXO));
                e_bready = !(e_ready && !is_w) && bvalid && out_m > 0;
                e_wv = wq_m.size() > 0;
                e_fv = fq_m.size() > 0;
                chk("rnd_ready", req_ready, e_ready);
                chk("rnd_bready", bready, e_bready);
                chk("rnd_unlock_valid", unlock_valid, (e_ready && !is_w) || e_bready);
                if (e_ready && !is_w) chk("rnd_unlock_req", unlock_thread, req_thread);
                else if (e_bready)    chk("rnd_unlock_bid", unlock_thread, bid);
                chk("rnd_outstanding", outstanding, out_m);
                chk("rnd_wvalid", wvalid, e_wv);
                if (e_wv) begin
                    a = cfg_base_addr + wq_m[0].locale * 4;
                    chk("rnd_waddr", waddr, a & 32'hFFFF_FFC0);
                    chk("rnd_wstrb", wstrb, 64'hF << (4 * (wq_m[0].locale % 16)));
                    chk("rnd_wdata", wdata, {16{wq_m[0].data}});
                    chk("rnd_wid", wid, wq_m[0].thread);
                end
                chk("rnd_finish_valid", finish_valid, e_fv);
                if (e_fv) begin
                    chk("rnd_finish_slot", finish_slot, fq_m[0].slot);
                    chk("rnd_finish_restore", finish_is_restore, fq_m[0].restore);
                end
                if (e_wv && wready) begin void'(wq_m.pop_front()); out_m++; end
                if (e_bready) out_m--;
                if (e_fv && finish_ready) void'(fq_m.pop_front());
                if (e_ready) begin
                    if (is_w) wq_m.push_back('{req_thread, req_locale, req_data});
                    fq_m.push_back('{req_slot, req_restore});
                end
            end
        end
        drain();
        wq_m.delete(); fq_m.delete();

`ifdef RW_WB_FLUSH_EN
        // Flush with two writes pending
        cfg_base_addr = 32'h1000;
        @(negedge clk); finish_ready = 1; req(1, 0, 32'h1, 4'd1, 6'd1, 32'h1);
        @(negedge clk); req(1, 0, 32'h2, 4'd2, 6'd2, 32'h2);
        @(negedge clk); req_valid = 0; flush_req = 1;
        @(negedge clk); flush_req = 0; req(0, 0, 32'h0, 4'd7, 6'd7, 32'h0); #1;
        chk("fl_ready_blocked", req_ready, 0);
        @(negedge clk); wready = 1;
        @(negedge clk);
        @(negedge clk); wready = 0; bvalid = 1; bid = 4'd1; #1;
        chk("fl_outstanding", outstanding, 2);
        chk("fl_ready_blocked2", req_ready, 0);
        chk("fl_not_done", flush_done, 0);
        @(negedge clk); bid = 4'd2;
        @(negedge clk); bvalid = 0; #1;
        chk("fl_done_pulse", flush_done, 1);
        @(negedge clk); #1;
        chk("fl_done_cleared", flush_done, 0);
        chk("fl_ready_restored", req_ready, 1);
        @(negedge clk); req_valid = 0;
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
